round_ctrl: RTL and testbench
=============================

# round_ctrl

Game-round sequencer for the two-player tank game. It gates the shared keyboard keycode to both tank objects and turns collision-logic hit levels into scores. It also pulses each tank's respawn input (`was_hit`) and runs the countdown, respawn and game-over phases. It sits between the keyboard/collision logic and the two tank instances, and is clocked by the frame clock.

## Interface
- `COUNTDOWN_FRAMES`, default 180: frames spent in COUNTDOWN before play begins. Must be ≥1.
- `RESPAWN_FRAMES`, default 120: frames of frozen input after a hit. Must be ≥1.
- `WIN_SCORE`, default 5: score that ends the game. Range 1..15.
- `frame_clk`  in  1  frame clock, the single clock.
- `Reset_n`  in  1  asynchronous, active-low reset.
- `keycode_in`  in  8  raw keyboard keycode.
- `hit1`  in  1  level: tank 1 is hit (by player 2's shell).
- `hit2`  in  1  level: tank 2 is hit.
- `keycode_p1`  out  8  gated keycode to tank 1.
- `keycode_p2`  out  8  gated keycode to tank 2.
- `respawn1`  out  1  one-frame pulse to tank 1 `was_hit`.
- `respawn2`  out  1  one-frame pulse to tank 2 `was_hit`.
- `score1`  out  4  player 1 score.
- `score2`  out  4  player 2 score.
- `winner`  out  2  00 none, 01 P1, 10 P2, 11 draw.
- `state`  out  3  current FSM state, for the HUD.

## Operation
- Reset (async, `Reset_n`=0) sets these values: state IDLE, scores 0, winner 00, keycode outputs 8'd0, respawn pulses 0, timer 0, hit history 0.
- Hit detection is on the rising edge only: `hitN & ~hitN_d`. A level held across many frames scores once.
- **IDLE**
  - Outputs: keycodes 0.
  - `keycode_in`==KEY_ENTER (8'd40) → COUNTDOWN. Timer loads COUNTDOWN_FRAMES, scores clear to 0, `respawn1` and `respawn2` pulse.
- **COUNTDOWN**
  - Outputs: keycodes 0.
  - Timer decrements each frame. Timer==1 → PLAY.
  - Hits are ignored.
- **PLAY**
  - `keycode_p1` and `keycode_p2` are registered copies of `keycode_in`.
  - A `hit1` edge increments `score2` and pulses `respawn1`.
  - A `hit2` edge increments `score1` and pulses `respawn2`.
  - Both edges in the same frame: both scores increment and both tanks respawn.
  - After any hit, if any new score equals WIN_SCORE → GAMEOVER. Otherwise → RESPAWN with the timer loaded with RESPAWN_FRAMES.
- **RESPAWN**
  - Outputs: keycodes 0.
  - Hit edges are ignored, but the hit history still updates.
  - Timer==1 → PLAY.
- **GAMEOVER**
  - Outputs: keycodes 0.
  - `winner` is set on entry: 01 or 10 for a single winner, 11 when both scores reach WIN_SCORE in the same frame.
  - KEY_ENTER → COUNTDOWN with the same actions as from IDLE, and `winner` cleared.
- KEY_ENTER in any state other than IDLE or GAMEOVER is ignored. It is forwarded as a normal keycode during PLAY.
- Arithmetic:
  - Scores are 4-bit and never exceed WIN_SCORE, because the FSM leaves PLAY first.
  - The timer is `$clog2(max(COUNTDOWN_FRAMES,RESPAWN_FRAMES)+1)` bits, unsigned, and never decrements below 1.

## Timing
- All outputs are registered. Keycode latency in PLAY is 1 frame.
- Respawn pulse:
  - Asserted for exactly one frame, in the cycle after the hit edge is sampled.
  - Score and state update in that same cycle.
- COUNTDOWN lasts exactly COUNTDOWN_FRAMES cycles. RESPAWN lasts exactly RESPAWN_FRAMES cycles.
- A hit edge in the last frame of PLAY before a reset is lost. Reset mid-phase returns to IDLE immediately and asynchronously.

## Configuration
- `ROUND_CTRL_PAUSE_EN` defined:
  - KEY_P (8'd19) in PLAY → PAUSED. The timer is untouched and keycodes are 0.
  - In PAUSED, hit edges are ignored.
  - KEY_P → PLAY, and only on a new press, i.e. after `keycode_in` has differed from KEY_P for at least one frame.
  - A press must be released before it toggles again.
- Undefined: the PAUSED state does not exist and KEY_P is forwarded as an ordinary keycode.

## Structure
- Shared package `round_pkg` holds:
  - the `round_state_t` enum: IDLE, COUNTDOWN, PLAY, RESPAWN, GAMEOVER, PAUSED;
  - the KEY_ENTER and KEY_P constants;
  - the `winner` encodings.
- Sub-module `frame_timer`: load, decrement-to-1 down-counter with a `done` flag, parameterized width.

## Test plan
- Reset asserted mid-RESPAWN with score1=2 → state IDLE, scores 0, keycodes 0, winner 00, same cycle.
- KEY_ENTER in IDLE → both respawn pulses for 1 frame; state PLAY exactly 180 frames later; `keycode_in`=8'd26 forwarded to both outputs 1 frame later.
- `hit1` held high for 50 frames in PLAY → score2=1 once, `respawn1` high for 1 frame, keycodes 0 for 120 frames, then PLAY.
- Scores 4–4, `hit1` and `hit2` rise in the same frame → scores 5–5, GAMEOVER, winner=11, both respawns pulse.
- Score1=4, `hit2` edge → GAMEOVER, winner=01; then KEY_ENTER → COUNTDOWN, scores 0, winner 00.
- With PAUSE_EN defined: KEY_P in PLAY → PAUSED; KEY_P held → stays PAUSED; release then press → PLAY; a hit edge while PAUSED → no score change.

Source files
------------

// File: rtl/round_ctrl_pkg.sv
// Shared types and constants for the tank-game round sequencer.
package round_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      COUNTDOWN = 3'd1,
      PLAY      = 3'd2,
      RESPAWN   = 3'd3,
      GAMEOVER  = 3'd4,
      PAUSED    = 3'd5
   } round_state_t;

   localparam logic [7:0] KEY_ENTER = 8'd40;
   localparam logic [7:0] KEY_P     = 8'd19;

   localparam logic [1:0] WIN_NONE = 2'b00;
   localparam logic [1:0] WIN_P1   = 2'b01;
   localparam logic [1:0] WIN_P2   = 2'b10;
   localparam logic [1:0] WIN_DRAW = 2'b11;

endpackage

// File: rtl/round_ctrl_if.sv
// Keyboard/collision inputs and tank/HUD outputs of the round sequencer.
interface round_ctrl_if;
   logic [7:0] keycode_in;
   logic       hit1;
   logic       hit2;
   logic [7:0] keycode_p1;
   logic [7:0] keycode_p2;
   logic       respawn1;
   logic       respawn2;
   logic [3:0] score1;
   logic [3:0] score2;
   logic [1:0] winner;
   logic [2:0] state;

   modport master (
      output keycode_in, hit1, hit2,
      input  keycode_p1, keycode_p2, respawn1, respawn2,
             score1, score2, winner, state
   );

   modport slave (
      input  keycode_in, hit1, hit2,
      output keycode_p1, keycode_p2, respawn1, respawn2,
             score1, score2, winner, state
   );
endinterface

// File: rtl/round_ctrl_frame_timer.sv
// Loadable down-counter that stops at 1; done flags the final frame of a phase.
module frame_timer #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         done
);

   localparam logic [W-1:0] ONE = W'(1);

   logic [W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (load)
         count_d = load_val;
      else if (dec && (count_q > ONE))
         count_d = count_q - ONE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         count_q <= '0;
      else
         count_q <= count_d;
   end

   assign done = (count_q == ONE);

endmodule

// File: rtl/round_ctrl.sv
// Round sequencer: countdown, play, respawn and game-over phases with scoring.
// Optional pause on KEY_P when ROUND_CTRL_PAUSE_EN is defined.
module round_ctrl
   import round_pkg::*;
#(
   parameter int COUNTDOWN_FRAMES = 180,
   parameter int RESPAWN_FRAMES   = 120,
   parameter int WIN_SCORE        = 5
) (
   input logic         frame_clk,
   input logic         Reset_n,
   round_ctrl_if.slave bus
);

   localparam int TMR_MAX = (COUNTDOWN_FRAMES > RESPAWN_FRAMES) ? COUNTDOWN_FRAMES : RESPAWN_FRAMES;
   localparam int TMR_W   = $clog2(TMR_MAX + 1);
   localparam logic [TMR_W-1:0] CD_LOAD = TMR_W'(COUNTDOWN_FRAMES);
   localparam logic [TMR_W-1:0] RS_LOAD = TMR_W'(RESPAWN_FRAMES);
   localparam logic [3:0]       WIN     = 4'(WIN_SCORE);

   round_state_t state_q, state_d;
   logic [3:0]   score1_q, score1_d, score2_q, score2_d;
   logic [1:0]   winner_q, winner_d;
   logic [7:0]   keycode_q, keycode_d;
   logic         resp1_q, resp1_d, resp2_q, resp2_d;
   logic         hist1_q, hist2_q;
   logic         edge1, edge2, enter;
   logic [3:0]   s1_inc, s2_inc;
   logic         tmr_load, tmr_dec, tmr_done;
   logic [TMR_W-1:0] tmr_val;

`ifdef ROUND_CTRL_PAUSE_EN
   logic pkey_q, p_press;
   assign p_press = (bus.keycode_in == KEY_P) && !pkey_q;
`endif

   assign edge1  = bus.hit1 & ~hist1_q;
   assign edge2  = bus.hit2 & ~hist2_q;
   assign enter  = (bus.keycode_in == KEY_ENTER);
   // A hit on tank 1 is a point for player 2 and vice versa.
   assign s1_inc = score1_q + {3'b000, edge2};
   assign s2_inc = score2_q + {3'b000, edge1};

   frame_timer #(.W(TMR_W)) u_timer (
      .clk      (frame_clk),
      .rst_n    (Reset_n),
      .load     (tmr_load),
      .load_val (tmr_val),
      .dec      (tmr_dec),
      .done     (tmr_done)
   );

   always_comb begin
      state_d  = state_q;
      score1_d = score1_q;
      score2_d = score2_q;
      winner_d = winner_q;
      resp1_d  = 1'b0;
      resp2_d  = 1'b0;
      tmr_load = 1'b0;
      tmr_dec  = 1'b0;
      tmr_val  = CD_LOAD;
      case (state_q)
         IDLE, GAMEOVER: begin
            if (enter) begin
               state_d  = COUNTDOWN;
               tmr_load = 1'b1;
               score1_d = 4'd0;
               score2_d = 4'd0;
               winner_d = WIN_NONE;
               resp1_d  = 1'b1;
               resp2_d  = 1'b1;
            end
         end
         COUNTDOWN, RESPAWN: begin
            if (tmr_done) state_d = PLAY;
            else          tmr_dec = 1'b1;
         end
         PLAY: begin
            if (edge1 || edge2) begin
               score1_d = s1_inc;
               score2_d = s2_inc;
               resp1_d  = edge1;
               resp2_d  = edge2;
               if ((s1_inc == WIN) || (s2_inc == WIN)) begin
                  state_d  = GAMEOVER;
                  winner_d = {s2_inc == WIN, s1_inc == WIN};
               end else begin
                  state_d  = RESPAWN;
                  tmr_load = 1'b1;
                  tmr_val  = RS_LOAD;
               end
            end
`ifdef ROUND_CTRL_PAUSE_EN
            else if (p_press) begin
               state_d = PAUSED;
            end
`endif
         end
`ifdef ROUND_CTRL_PAUSE_EN
         PAUSED: begin
            if (p_press) state_d = PLAY;
         end
`endif
         default: state_d = IDLE;
      endcase
      // Gate on the next state so keycodes are live only while PLAY is visible.
      keycode_d = (state_d == PLAY) ? bus.keycode_in : 8'd0;
   end

   always_ff @(posedge frame_clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q   <= IDLE;
         score1_q  <= 4'd0;
         score2_q  <= 4'd0;
         winner_q  <= WIN_NONE;
         keycode_q <= 8'd0;
         resp1_q   <= 1'b0;
         resp2_q   <= 1'b0;
         hist1_q   <= 1'b0;
         hist2_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         score1_q  <= score1_d;
         score2_q  <= score2_d;
         winner_q  <= winner_d;
         keycode_q <= keycode_d;
         resp1_q   <= resp1_d;
         resp2_q   <= resp2_d;
         hist1_q   <= bus.hit1;
         hist2_q   <= bus.hit2;
      end
   end

`ifdef ROUND_CTRL_PAUSE_EN
   always_ff @(posedge frame_clk or negedge Reset_n) begin
      if (!Reset_n) pkey_q <= 1'b0;
      else          pkey_q <= (bus.keycode_in == KEY_P);
   end
`endif

   assign bus.keycode_p1 = keycode_q;
   assign bus.keycode_p2 = keycode_q;
   assign bus.respawn1   = resp1_q;
   assign bus.respawn2   = resp2_q;
   assign bus.score1     = score1_q;
   assign bus.score2     = score2_q;
   assign bus.winner     = winner_q;
   assign bus.state      = state_q;

endmodule

// File: tb/tb_round_ctrl.sv
// Directed bench for round_ctrl with a frame-level behavioural model checked every frame.
module tb_round_ctrl;

   localparam int CDF = 180;
   localparam int RSF = 120;
   localparam int WSC = 5;
`ifdef ROUND_CTRL_PAUSE_EN
   localparam bit PAUSE = 1'b1;
`else
   localparam bit PAUSE = 1'b0;
`endif

   localparam int S_IDLE = 0, S_CD = 1, S_PLAY = 2, S_RS = 3, S_GO = 4, S_PAUSE = 5;

   logic clk = 1'b0;
   logic rst_n;
   int   n_tests = 0;
   int   n_fail  = 0;

   round_ctrl_if bus();

   round_ctrl #(
      .COUNTDOWN_FRAMES (CDF),
      .RESPAWN_FRAMES   (RSF),
      .WIN_SCORE        (WSC)
   ) dut (
      .frame_clk (clk),
      .Reset_n   (rst_n),
      .bus       (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: phase, frames remaining in a timed phase, scores, winner, pulses.
   int         m_ph, m_left, m_s1, m_s2, m_w;
   logic       m_r1, m_r2, m_h1, m_h2, m_pk;
   logic [7:0] m_kc;

   task automatic model_reset();
      m_ph = S_IDLE; m_left = 0; m_s1 = 0; m_s2 = 0; m_w = 0;
      m_r1 = 0; m_r2 = 0; m_h1 = 0; m_h2 = 0; m_pk = 0; m_kc = 8'd0;
   endtask

   task automatic model_step(input logic [7:0] k, input logic a1, input logic a2);
      logic e1, e2, pnew;
      e1 = a1 && !m_h1;
      e2 = a2 && !m_h2;
      pnew = (k == 8'd19) && !m_pk;
      m_h1 = a1; m_h2 = a2; m_pk = (k == 8'd19);
      m_r1 = 0; m_r2 = 0;
      case (m_ph)
         S_IDLE, S_GO:
            if (k == 8'd40) begin
               m_ph = S_CD; m_left = CDF; m_s1 = 0; m_s2 = 0; m_w = 0; m_r1 = 1; m_r2 = 1;
            end
         S_CD, S_RS: begin
            m_left = m_left - 1;
            if (m_left == 0) m_ph = S_PLAY;
         end
         S_PLAY:
            if (e1 || e2) begin
               if (e1) m_s2 = m_s2 + 1;
               if (e2) m_s1 = m_s1 + 1;
               m_r1 = e1; m_r2 = e2;
               if (m_s1 == WSC || m_s2 == WSC) begin
                  m_ph = S_GO;
                  m_w = (m_s1 == WSC ? 1 : 0) + (m_s2 == WSC ? 2 : 0);
               end else begin
                  m_ph = S_RS; m_left = RSF;
               end
            end else if (PAUSE && pnew) begin
               m_ph = S_PAUSE;
            end
         S_PAUSE: if (pnew) m_ph = S_PLAY;
         default: m_ph = S_IDLE;
      endcase
      m_kc = (m_ph == S_PLAY) ? k : 8'd0;
   endtask

   initial begin
      logic [7:0] ck;
      logic       c1, c2, crst;
      forever begin
         @(posedge clk);
         ck = bus.keycode_in; c1 = bus.hit1; c2 = bus.hit2; crst = rst_n;
         @(negedge clk);
         if (!rst_n)    model_reset();
         else if (crst) model_step(ck, c1, c2);
         chk("state",  bus.state,      m_ph);
         chk("score1", bus.score1,     m_s1);
         chk("score2", bus.score2,     m_s2);
         chk("winner", bus.winner,     m_w);
         chk("kc_p1",  bus.keycode_p1, m_kc);
         chk("kc_p2",  bus.keycode_p2, m_kc);
         chk("resp1",  bus.respawn1,   m_r1);
         chk("resp2",  bus.respawn2,   m_r2);
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_state(input int st, output int n);
      n = 0;
      while (bus.state !== 3'(st) && n < 2000) begin
         step(1);
         n++;
      end
      if (n >= 2000) chk("wait_timeout", n, 0);
   endtask

   task automatic hit(input logic a1, input logic a2);
      int n;
      bus.hit1 = a1; bus.hit2 = a2;
      step(1);
      bus.hit1 = 0; bus.hit2 = 0;
      wait_state(S_PLAY, n);
   endtask

   initial begin
      int n;
      rst_n = 0;
      bus.keycode_in = 8'd0; bus.hit1 = 0; bus.hit2 = 0;
      step(3);
      chk("rst_state", bus.state, 0);
      chk("rst_kc", bus.keycode_p1, 0);
      rst_n = 1;

      bus.keycode_in = 8'd26;
      step(2);
      chk("idle_kc", bus.keycode_p1, 0);

      bus.keycode_in = 8'd40;
      step(1);
      chk("start_state", bus.state, S_CD);
      chk("start_resp1", bus.respawn1, 1);
      chk("start_resp2", bus.respawn2, 1);
      bus.keycode_in = 8'd26;
      n = 0;
      while (bus.state !== 3'(S_PLAY) && n < 1000) begin
         bus.hit1 = (n == 5);
         step(1);
         n++;
      end
      bus.hit1 = 0;
      chk("cd_len", n, CDF);
      chk("cd_hit_ignored", bus.score2, 0);
      chk("play_kc1", bus.keycode_p1, 26);
      chk("play_kc2", bus.keycode_p2, 26);

      bus.keycode_in = 8'd40;
      step(1);
      chk("enter_fwd", bus.keycode_p1, 40);
      chk("enter_ignored", bus.state, S_PLAY);
      bus.keycode_in = 8'd26;

      bus.hit1 = 1;
      step(1);
      chk("hold_resp1", bus.respawn1, 1);
      chk("hold_score2", bus.score2, 1);
      chk("hold_state", bus.state, S_RS);
      chk("hold_kc", bus.keycode_p1, 0);
      step(49);
      chk("hold_once", bus.score2, 1);
      chk("hold_resp1_low", bus.respawn1, 0);
      bus.hit1 = 0;
      wait_state(S_PLAY, n);
      chk("rs_len", n, RSF - 49);

      repeat (4) hit(0, 1);
      repeat (3) hit(1, 0);
      chk("pre_s1", bus.score1, 4);
      chk("pre_s2", bus.score2, 4);
      bus.hit1 = 1; bus.hit2 = 1;
      step(1);
      bus.hit1 = 0; bus.hit2 = 0;
      chk("draw_s1", bus.score1, 5);
      chk("draw_s2", bus.score2, 5);
      chk("draw_state", bus.state, S_GO);
      chk("draw_winner", bus.winner, 3);
      chk("draw_resp1", bus.respawn1, 1);
      chk("draw_resp2", bus.respawn2, 1);
      step(3);

      bus.keycode_in = 8'd40;
      step(1);
      chk("restart_state", bus.state, S_CD);
      chk("restart_winner", bus.winner, 0);
      bus.keycode_in = 8'd0;
      wait_state(S_PLAY, n);

      repeat (4) hit(0, 1);
      bus.hit2 = 1;
      step(1);
      bus.hit2 = 0;
      chk("p1win_state", bus.state, S_GO);
      chk("p1win_winner", bus.winner, 1);
      chk("p1win_s1", bus.score1, 5);
      bus.keycode_in = 8'd40;
      step(1);
      chk("clear_state", bus.state, S_CD);
      chk("clear_s1", bus.score1, 0);
      chk("clear_winner", bus.winner, 0);
      bus.keycode_in = 8'd0;
      wait_state(S_PLAY, n);

`ifdef ROUND_CTRL_PAUSE_EN
      bus.keycode_in = 8'd19;
      step(1);
      chk("pause_state", bus.state, S_PAUSE);
      chk("pause_kc", bus.keycode_p1, 0);
      step(3);
      chk("pause_held", bus.state, S_PAUSE);
      bus.hit1 = 1;
      step(1);
      bus.hit1 = 0;
      step(1);
      chk("pause_hit", bus.score2, 0);
      bus.keycode_in = 8'd0;
      step(1);
      chk("pause_release", bus.state, S_PAUSE);
      bus.keycode_in = 8'd19;
      step(1);
      chk("resume_state", bus.state, S_PLAY);
      bus.keycode_in = 8'd0;
      step(1);
`else
      bus.keycode_in = 8'd19;
      step(1);
      chk("keyp_fwd", bus.keycode_p1, 19);
      chk("keyp_state", bus.state, S_PLAY);
      bus.keycode_in = 8'd0;
      step(1);
`endif

      hit(0, 1);
      bus.hit2 = 1;
      step(1);
      bus.hit2 = 0;
      chk("mid_s1", bus.score1, 2);
      step(10);
      #2 rst_n = 0;
      #1;
      chk("arst_state", bus.state, 0);
      chk("arst_s1", bus.score1, 0);
      chk("arst_kc", bus.keycode_p1, 0);
      chk("arst_winner", bus.winner, 0);
      chk("arst_resp", bus.respawn2, 0);
      step(2);
      rst_n = 1;
      step(3);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
